wb_bus_arbiter: RTL
===================

# wb_bus_arbiter

Round-robin Wishbone bus arbiter that generates the `gnt_wb_i` grant consumed by each NIC's noc2wb master and by the other masters sharing the node-side Wishbone bus. It samples the `CYC` lines of up to `N_MASTERS` masters and grants the bus to exactly one at a time. It holds the grant for the whole bus cycle, across any burst, and rotates priority after each release. An optional watchdog forcibly revokes a grant held too long.

## Interface
- `N_MASTERS`, default 2: number of Wishbone masters; the NIC noc2wb master is index 0 by convention. Legal range 1..16.
- `N_BITS_MASTER_ID`, default `clog2(N_MASTERS)`, minimum 1: width of the grant index.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles, ≥2. Used only when the timeout feature is compiled in.
- `N_BITS_TIMEOUT`, default `clog2(TIMEOUT_CYCLES)`: watchdog counter width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cyc_i`  in  `N_MASTERS`: bit k is the `CYC_O` of master k.
- `gnt_o`  out  `N_MASTERS`: one-hot-or-zero grant; bit 0 drives the NIC `gnt_wb_i`.
- `gnt_id_o`  out  `N_BITS_MASTER_ID`: index of the current owner; valid only while `bus_busy_o` is 1.
- `bus_busy_o`  out  1: high while any grant is active; equals the OR of `gnt_o`.
- `timeout_o`  out  1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GRANT, BLOCK. BLOCK exists only with the timeout feature.
- IDLE:
  - If `cyc_i` is nonzero, select the first set bit searching upward from `last_owner+1`, wrapping modulo `N_MASTERS`.
  - Register the grant and go to GRANT.
  - `last_owner` updates to the selected index.
- GRANT:
  - Grant is held while `cyc_i[owner]`=1. Requests from other masters are ignored.
  - When `cyc_i[owner]`=0, clear the grant and go to IDLE. Priority rotates because the search starts after `last_owner`.
- A master that holds `cyc_i` permanently high still releases between its own cycles only if it drops `CYC`. Fairness relies on masters dropping `CYC` between transactions, as the NIC does.
- Reset: state IDLE, `gnt_o`=0, `gnt_id_o`=0, `bus_busy_o`=0, `timeout_o`=0, `last_owner`=`N_MASTERS-1`. With this value the first search starts at master 0.
- Reset asserted mid-grant: the grant drops in the cycle after the reset edge. No handshake is attempted with the master.
- `N_MASTERS`=1: the search is trivial, and the grant follows `cyc_i[0]` with the same one-cycle latency.

## Timing
- Grant latency: `cyc_i` rising in cycle t (state IDLE) gives `gnt_o` high in cycle t+1.
- Release latency: `cyc_i[owner]` falling in cycle t gives `gnt_o` low in cycle t+1. IDLE occupies cycle t+1.
- The earliest next grant is in cycle t+2. This guarantees one bus-idle cycle between owners, so two masters never drive the bus in the same cycle.
- All outputs are registered. There is no combinational path from `cyc_i` to any output.

## Configuration
- Macro `WB_ARB_TIMEOUT_EN`.
- Defined:
  - A counter increments every cycle in GRANT and clears on entering GRANT.
  - If the counter reaches `TIMEOUT_CYCLES-1` while `cyc_i[owner]`=1: in the next cycle `gnt_o`=0 and `timeout_o`=1 for one cycle, and the state becomes BLOCK.
  - BLOCK masks the timed-out master and goes to IDLE once that master's `cyc_i` bit is 0.
  - While in BLOCK, no grant is issued to any master.
- Undefined:
  - No counter and no BLOCK state.
  - `timeout_o` is tied to 0.
  - A grant is held indefinitely.

## Structure
- Constants `WB_ARB_MAX_MASTERS` (16) and `WB_ARB_DEFAULT_TIMEOUT` (256) go in `NIC-defines.v`.
- `clog2` comes from `NIC_utils.vh`.
- Sub-module `rr_priority_picker`: a combinational rotate-search, with inputs request vector and start index and outputs found flag and index.
- The FSM, grant register and watchdog live in the top module.

## Test plan
- Single request: after reset, `cyc_i`=2'b01 at cycle 3 → `gnt_o`=2'b01 and `gnt_id_o`=0 at cycle 4. `cyc_i`=0 at cycle 10 → `gnt_o`=0 at cycle 11.
- Simultaneous requests: `cyc_i`=2'b11 from reset → master 0 is granted first. Master 0 drops `CYC` for one cycle → master 1 is granted two cycles after the drop.
- Rotation with 4 masters: all request continuously and each drops `CYC` for one cycle after 5 cycles of ownership → grant order 0,1,2,3,0. There is always one cycle with `gnt_o`=0 between owners.
- Hold during burst: owner 1 keeps `cyc_i` high for 20 cycles while master 0 requests → `gnt_o` stays 2'b10 for all 20 cycles.
- Reset mid-grant: `rst` pulsed while `gnt_o`=2'b10 → all outputs are 0 on the next cycle, and master 0 wins the next arbitration.
- Timeout (`WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): master 0 holds `CYC` forever and master 1 requests → `gnt_o`[0] clears after 8 cycles with `timeout_o` pulsing once. Master 1 is not granted until master 0 drops `CYC`. The grant then goes to master 1 one cycle after IDLE.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared constants, helper function and FSM state type for wb_bus_arbiter.
// The BLOCK state only exists when WB_ARB_TIMEOUT_EN is defined.
package wb_bus_arbiter_pkg;

  localparam int unsigned WB_ARB_MAX_MASTERS     = 16;
  localparam int unsigned WB_ARB_DEFAULT_TIMEOUT = 256;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3, clog2(9) = 4.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BLOCK
  } arb_state_t;
`else
  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_t;
`endif

endpackage

// File: rtl/wb_bus_arbiter_picker.sv
// rr_priority_picker: combinational rotate-search. Returns the first set
// request bit found searching upward from start_i, wrapping modulo N_REQ.
module rr_priority_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned N_BITS_IDX = 1
) (
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_BITS_IDX-1:0] start_i,
  output logic                  found_o,
  output logic [N_BITS_IDX-1:0] idx_o
);

  int unsigned w_k;

  // Walk all positions starting at start_i; first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_k     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_k = (32'(start_i) + i) % N_REQ;
      if (!found_o && req_i[w_k]) begin
        found_o = 1'b1;
        idx_o   = N_BITS_IDX'(w_k);
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus arbiter. Grants one master at a time, holds the
// grant for the whole CYC period and rotates priority after each release.
// Optional watchdog compiled in with macro WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS        = 2,
  parameter int unsigned N_BITS_MASTER_ID = (clog2(N_MASTERS) < 1) ? 1 : clog2(N_MASTERS),
  parameter int unsigned TIMEOUT_CYCLES   = WB_ARB_DEFAULT_TIMEOUT,
  parameter int unsigned N_BITS_TIMEOUT   = clog2(TIMEOUT_CYCLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        cyc_i,
  output logic [N_MASTERS-1:0]        gnt_o,
  output logic [N_BITS_MASTER_ID-1:0] gnt_id_o,
  output logic                        bus_busy_o,
  output logic                        timeout_o
);

  arb_state_t                  r_state,      w_state_nxt;
  logic [N_MASTERS-1:0]        r_gnt,        w_gnt_nxt;
  logic [N_BITS_MASTER_ID-1:0] r_gnt_id,     w_id_nxt;
  logic [N_BITS_MASTER_ID-1:0] r_last_owner, w_last_nxt;
  logic [N_BITS_MASTER_ID-1:0] w_start;
  logic [N_BITS_MASTER_ID-1:0] w_pick;
  logic                        w_found;
  logic                        w_own_req;
`ifdef WB_ARB_TIMEOUT_EN
  logic                        r_timeout,    w_tout_nxt;
  logic [N_BITS_TIMEOUT-1:0]   r_cnt,        w_cnt_nxt;
`endif

  // Search starts one past the previous owner, wrapping to 0.
  assign w_start   = (32'(r_last_owner) == N_MASTERS - 1) ? '0 : r_last_owner + 1'b1;
  assign w_own_req = cyc_i[r_gnt_id];

  rr_priority_picker #(
    .N_REQ      (N_MASTERS),
    .N_BITS_IDX (N_BITS_MASTER_ID)
  ) u_picker (
    .req_i   (cyc_i),
    .start_i (w_start),
    .found_o (w_found),
    .idx_o   (w_pick)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_gnt_id;
    w_last_nxt  = r_last_owner;
`ifdef WB_ARB_TIMEOUT_EN
    w_tout_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_pick] = 1'b1;
          w_id_nxt          = w_pick;
          w_last_nxt        = w_pick;
          w_state_nxt       = ST_GRANT;
`ifdef WB_ARB_TIMEOUT_EN
          w_cnt_nxt         = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!w_own_req) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (r_cnt == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
          w_gnt_nxt   = '0;
          w_tout_nxt  = 1'b1;
          w_state_nxt = ST_BLOCK;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      // r_gnt_id still names the timed-out master; wait for it to drop CYC.
      ST_BLOCK: begin
        if (!w_own_req) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_gnt_id     <= '0;
      r_last_owner <= N_BITS_MASTER_ID'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_gnt_id     <= w_id_nxt;
      r_last_owner <= w_last_nxt;
`ifdef WB_ARB_TIMEOUT_EN
      r_timeout    <= w_tout_nxt;
      r_cnt        <= w_cnt_nxt;
`endif
    end
  end

  assign gnt_o      = r_gnt;
  assign gnt_id_o   = r_gnt_id;
  assign bus_busy_o = |r_gnt;
`ifdef WB_ARB_TIMEOUT_EN
  assign timeout_o  = r_timeout;
`else
  assign timeout_o  = 1'b0;
`endif

endmodule
